// File: rtl/bpm_autocorr_ctrl.sv
// Flux-to-autocorrelation sequencer: decimates flux into N-sample windows, waits (bounded) for the BPM
// result, range-checks and smooths it. Forward latency 1 cycle, result latency 2 cycles; no backpressure.
module bpm_autocorr_ctrl #(
    parameter int W       = 16,
    parameter int N       = 8,
    parameter int DECIM   = 4,
    parameter int TIMEOUT = 1024,
    parameter int BPM_MIN = 60,
    parameter int BPM_MAX = 200
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         flux_in_valid,
    input  logic [W-1:0] flux_in,
    input  logic         beat_in,
    output logic         ac_flux_valid,
    output logic [W-1:0] ac_flux,
    output logic         ac_beat_valid,
    output logic         ac_clear,
    input  logic [W-1:0] ac_bpm,
    input  logic         ac_bpm_valid,
    output logic [W-1:0] bpm_out,
    output logic         bpm_out_valid,
    output logic         timeout_err,
    output logic [1:0]   state_out
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
    localparam logic [CW-1:0] FWD_LAST  = CW'(N - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [W-1:0]  BPM_LO    = W'(BPM_MIN);
    localparam logic [W-1:0]  BPM_HI    = W'(BPM_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] dec_cnt;
    logic [CW-1:0] fwd_cnt;
    logic [TW-1:0] wait_cnt;
    logic [W-1:0]  bpm_cap;
    logic          have_hist;
    logic [W:0]    avg_sum;
    logic          in_range;

    logic          fwd_fire;
    logic          last_fwd;
    logic          res_fire;
    logic          tmo_fire;
    logic          accept;
    logic          clear_req;

    assign in_range  = (bpm_cap >= BPM_LO) && (bpm_cap <= BPM_HI);
    assign avg_sum   = {1'b0, bpm_out} + {1'b0, bpm_cap};
    assign state_out = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = enable ? FILL : IDLE;
            FILL: begin
                if (!enable)       next_state = IDLE;
                else if (last_fwd) next_state = WAIT;
            end
            WAIT: begin
                if (!enable)       next_state = IDLE;
                else if (res_fire) next_state = HOLD;
                else if (tmo_fire) next_state = FILL;
            end
            HOLD:    next_state = enable ? FILL : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A result arriving on the timeout cycle takes priority over the timeout.
    always_comb begin
        fwd_fire  = 1'b0;
        last_fwd  = 1'b0;
        res_fire  = 1'b0;
        tmo_fire  = 1'b0;
        accept    = 1'b0;
        clear_req = 1'b0;
        case (state)
            IDLE: clear_req = enable;
            FILL: begin
                if (!enable) begin
                    clear_req = 1'b1;
                end else begin
                    fwd_fire = flux_in_valid && (dec_cnt == '0);
                    last_fwd = fwd_fire && (fwd_cnt == FWD_LAST);
                end
            end
            WAIT: begin
                if (!enable) begin
                    clear_req = 1'b1;
                end else if (ac_bpm_valid) begin
                    res_fire = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    tmo_fire  = 1'b1;
                    clear_req = 1'b1;
                end
            end
            HOLD: begin
                if (!enable) clear_req = 1'b1;
                else         accept    = in_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt       <= '0;
            fwd_cnt       <= '0;
            wait_cnt      <= '0;
            bpm_cap       <= '0;
            have_hist     <= 1'b0;
            ac_flux_valid <= 1'b0;
            ac_flux       <= '0;
            ac_beat_valid <= 1'b0;
            ac_clear      <= 1'b0;
            bpm_out       <= '0;
            bpm_out_valid <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            ac_flux_valid <= fwd_fire;
            ac_beat_valid <= fwd_fire && beat_in;
            ac_clear      <= clear_req;
            bpm_out_valid <= accept;
            if (fwd_fire) ac_flux <= flux_in;

            if (state == FILL && enable) begin
                if (flux_in_valid) begin
                    if (last_fwd) begin
                        dec_cnt <= '0;
                        fwd_cnt <= '0;
                    end else begin
                        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DW'(1);
                        if (fwd_fire) fwd_cnt <= fwd_cnt + CW'(1);
                    end
                end
            end else begin
                dec_cnt <= '0;
                fwd_cnt <= '0;
            end

            if (state == WAIT && enable && !ac_bpm_valid && !tmo_fire) wait_cnt <= wait_cnt + TW'(1);
            else                                                        wait_cnt <= '0;

            if (res_fire) bpm_cap <= ac_bpm;

            if (tmo_fire)    timeout_err <= 1'b1;
            else if (accept) timeout_err <= 1'b0;

            // First accepted result seeds the average; later ones take the truncated mean.
            if (accept) begin
                bpm_out   <= have_hist ? W'(avg_sum >> 1) : bpm_cap;
                have_hist <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bpm_autocorr_ctrl.sv
// Randomised bench for bpm_autocorr_ctrl against a transaction-level model of windows and smoothing.
module tb_bpm_autocorr_ctrl;

    localparam int W       = 16;
    localparam int N       = 8;
    localparam int DECIM   = 4;
    localparam int TIMEOUT = 1024;
    localparam int BPM_MIN = 60;
    localparam int BPM_MAX = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         flux_in_valid;
    logic [W-1:0] flux_in;
    logic         beat_in;
    logic         ac_flux_valid;
    logic [W-1:0] ac_flux;
    logic         ac_beat_valid;
    logic         ac_clear;
    logic [W-1:0] ac_bpm;
    logic         ac_bpm_valid;
    logic [W-1:0] bpm_out;
    logic         bpm_out_valid;
    logic         timeout_err;
    logic [1:0]   state_out;

    bpm_autocorr_ctrl #(
        .W(W), .N(N), .DECIM(DECIM), .TIMEOUT(TIMEOUT), .BPM_MIN(BPM_MIN), .BPM_MAX(BPM_MAX)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .flux_in_valid(flux_in_valid), .flux_in(flux_in), .beat_in(beat_in),
        .ac_flux_valid(ac_flux_valid), .ac_flux(ac_flux), .ac_beat_valid(ac_beat_valid),
        .ac_clear(ac_clear), .ac_bpm(ac_bpm), .ac_bpm_valid(ac_bpm_valid),
        .bpm_out(bpm_out), .bpm_out_valid(bpm_out_valid), .timeout_err(timeout_err),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int clr_cnt = 0;
    int fq_v[$], fq_b[$], fq_c[$];
    int eq_v[$], eq_b[$], eq_c[$];
    int ov_v[$], ov_c[$];

    int m_bpm  = 0;
    bit m_hist = 1'b0;
    bit m_terr = 1'b0;

    always @(negedge clk) begin
        if (ac_clear) clr_cnt++;
        if (ac_flux_valid) begin
            fq_v.push_back(int'(ac_flux));
            fq_b.push_back(int'(ac_beat_valid));
            fq_c.push_back(cyc);
        end
        if (bpm_out_valid) begin
            ov_v.push_back(int'(bpm_out));
            ov_c.push_back(cyc);
        end
        if (ac_beat_valid) begin
            n_cmp++;
            if (!ac_flux_valid) begin
                n_bad++;
                $display("FAIL beat_qualify: ac_beat_valid=1 with ac_flux_valid=%0d at cycle %0d", ac_flux_valid, cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives strobes until nfwd samples are due, then `extra` more; expected forwards follow the
    // rule "k-th strobe of a window is forwarded when k is a multiple of DECIM".
    task automatic feed(input int nfwd, input int extra, input int base);
        int k  = 0;
        int fw = 0;
        int v;
        fq_v.delete(); fq_b.delete(); fq_c.delete();
        eq_v.delete(); eq_b.delete(); eq_c.delete();
        ov_v.delete(); ov_c.delete();
        while (fw < nfwd) begin
            repeat ($urandom_range(0, 2)) begin
                ac_bpm_valid = 1'($urandom_range(0, 1));
                ac_bpm       = W'($urandom_range(BPM_MIN, BPM_MAX));
                tick();
            end
            ac_bpm_valid  = 1'b0;
            v             = (base >= 0) ? base + k : int'($urandom_range(0, 65535));
            flux_in       = W'(v);
            beat_in       = 1'($urandom_range(0, 1));
            flux_in_valid = 1'b1;
            if (k % DECIM == 0) begin
                eq_v.push_back(v);
                eq_b.push_back(int'(beat_in));
                eq_c.push_back(cyc + 1);
                fw++;
            end
            k++;
            tick();
            flux_in_valid = 1'b0;
        end
        for (int i = 0; i < extra; i++) begin
            v             = (base >= 0) ? base + k : int'($urandom_range(0, 65535));
            flux_in       = W'(v);
            beat_in       = 1'($urandom_range(0, 1));
            flux_in_valid = 1'b1;
            k++;
            tick();
        end
        flux_in_valid = 1'b0;
    endtask

    task automatic present_result(input int b, output int d, output bit acc, output int s1, output int s2);
        acc = (b >= BPM_MIN) && (b <= BPM_MAX);
        if (acc) begin
            m_bpm  = m_hist ? (m_bpm + b) / 2 : b;
            m_hist = 1'b1;
            m_terr = 1'b0;
        end
        ac_bpm       = W'(b);
        ac_bpm_valid = 1'b1;
        d            = cyc;
        tick();
        ac_bpm_valid = 1'b0;
        s1           = int'(state_out);
        tick();
        s2           = int'(state_out);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({ac_flux_valid, ac_beat_valid, ac_clear, bpm_out_valid, timeout_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b required 00000",
                     {ac_flux_valid, ac_beat_valid, ac_clear, bpm_out_valid, timeout_err});
        end
        n_cmp++;
        if (ac_flux !== '0 || bpm_out !== '0) begin
            n_bad++;
            $display("FAIL reset_data: ac_flux=%0d bpm_out=%0d required 0", ac_flux, bpm_out);
        end
        n_cmp++;
        if (state_out !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d required 0", state_out);
        end
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (state_out !== 2'd0 || ac_clear !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_disabled: state=%0d ac_clear=%0d required 0/0", state_out, ac_clear);
        end
    endtask

    task automatic test_fill_window();
        int c0 = clr_cnt;
        enable = 1'b1;
        tick();
        n_cmp++;
        if (state_out !== 2'd1 || ac_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL start_fill: state=%0d ac_clear=%0d required 1/1", state_out, ac_clear);
        end
        feed(N, 3, 100);
        tick();
        n_cmp++;
        if (fq_v.size() != eq_v.size()) begin
            n_bad++;
            $display("FAIL fill_count: got %0d forwards required %0d", fq_v.size(), eq_v.size());
        end else begin
            for (int i = 0; i < eq_v.size(); i++) begin
                n_cmp++;
                if (fq_v[i] != eq_v[i] || fq_b[i] != eq_b[i] || fq_c[i] != eq_c[i]) begin
                    n_bad++;
                    $display("FAIL fill_fwd%0d: got val=%0d beat=%0d cyc=%0d required %0d/%0d/%0d",
                             i, fq_v[i], fq_b[i], fq_c[i], eq_v[i], eq_b[i], eq_c[i]);
                end
            end
        end
        n_cmp++;
        if (state_out !== 2'd2) begin
            n_bad++;
            $display("FAIL fill_to_wait: got state %0d required 2", state_out);
        end
        n_cmp++;
        if (clr_cnt - c0 != 1) begin
            n_bad++;
            $display("FAIL fill_clear_count: got %0d ac_clear pulses required 1", clr_cnt - c0);
        end
    endtask

    task automatic test_results();
        int res[8] = '{120, 128, 250, 40, 201, 59, 200, 60};
        int d, s1, s2;
        bit acc;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) feed(N, 0, -1);
            present_result(res[i], d, acc, s1, s2);
            n_cmp++;
            if (s1 != 3 || s2 != 1) begin
                n_bad++;
                $display("FAIL res%0d_states: got %0d,%0d required 3,1", res[i], s1, s2);
            end
            n_cmp++;
            if (ov_v.size() != (acc ? 1 : 0)) begin
                n_bad++;
                $display("FAIL res%0d_valid_count: got %0d required %0d", res[i], ov_v.size(), acc ? 1 : 0);
            end else if (acc) begin
                n_cmp++;
                if (ov_v[0] != m_bpm || ov_c[0] != d + 2) begin
                    n_bad++;
                    $display("FAIL res%0d_pulse: got bpm=%0d cyc=%0d required %0d/%0d",
                             res[i], ov_v[0], ov_c[0], m_bpm, d + 2);
                end
            end
            n_cmp++;
            if (int'(bpm_out) != m_bpm || timeout_err !== m_terr) begin
                n_bad++;
                $display("FAIL res%0d_hold: bpm_out=%0d terr=%0d required %0d/%0d",
                         res[i], bpm_out, timeout_err, m_bpm, m_terr);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int vals[2] = '{250, 90};
        int d, s1, s2;
        bit acc;
        feed(N, 0, -1);
        while (state_out === 2'd2 && n < TIMEOUT + 8) begin
            n++;
            tick();
        end
        m_terr = 1'b1;
        n_cmp++;
        if (n != TIMEOUT) begin
            n_bad++;
            $display("FAIL timeout_len: got %0d cycles in WAIT required %0d", n, TIMEOUT);
        end
        n_cmp++;
        if (state_out !== 2'd1 || ac_clear !== 1'b1 || timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_exit: state=%0d clr=%0d terr=%0d required 1/1/1",
                     state_out, ac_clear, timeout_err);
        end
        for (int i = 0; i < 2; i++) begin
            feed(N, 0, -1);
            present_result(vals[i], d, acc, s1, s2);
            n_cmp++;
            if (ov_v.size() != (acc ? 1 : 0) || int'(bpm_out) != m_bpm || timeout_err !== m_terr) begin
                n_bad++;
                $display("FAIL after_timeout_%0d: pulses=%0d bpm=%0d terr=%0d required %0d/%0d/%0d",
                         vals[i], ov_v.size(), bpm_out, timeout_err, acc ? 1 : 0, m_bpm, m_terr);
            end
        end
    endtask

    task automatic test_timeout_race();
        int c0, d, s1, s2;
        bit acc;
        int b = int'($urandom_range(BPM_MIN, BPM_MAX));
        feed(N, 0, -1);
        repeat (TIMEOUT - 1) tick();
        n_cmp++;
        if (state_out !== 2'd2) begin
            n_bad++;
            $display("FAIL race_pre_state: got %0d required 2", state_out);
        end
        c0 = clr_cnt;
        present_result(b, d, acc, s1, s2);
        n_cmp++;
        if (s1 != 3 || ov_v.size() != 1 || timeout_err !== 1'b0 || clr_cnt != c0) begin
            n_bad++;
            $display("FAIL race_result_wins: state=%0d pulses=%0d terr=%0d clears=%0d required 3/1/0/0",
                     s1, ov_v.size(), timeout_err, clr_cnt - c0);
        end
        n_cmp++;
        if (int'(bpm_out) != m_bpm) begin
            n_bad++;
            $display("FAIL race_bpm: got %0d required %0d", bpm_out, m_bpm);
        end
    endtask

    task automatic test_random_results();
        int d, s1, s2, b;
        bit acc;
        for (int r = 0; r < 6; r++) begin
            feed(N, int'($urandom_range(0, 2)), -1);
            b = int'($urandom_range(20, 260));
            present_result(b, d, acc, s1, s2);
            n_cmp++;
            if (fq_v.size() != eq_v.size()) begin
                n_bad++;
                $display("FAIL rnd%0d_fwd_count: got %0d required %0d", r, fq_v.size(), eq_v.size());
            end else begin
                for (int i = 0; i < eq_v.size(); i++) begin
                    n_cmp++;
                    if (fq_v[i] != eq_v[i] || fq_b[i] != eq_b[i] || fq_c[i] != eq_c[i]) begin
                        n_bad++;
                        $display("FAIL rnd%0d_fwd%0d: got %0d/%0d/%0d required %0d/%0d/%0d",
                                 r, i, fq_v[i], fq_b[i], fq_c[i], eq_v[i], eq_b[i], eq_c[i]);
                    end
                end
            end
            n_cmp++;
            if (s1 != 3 || ov_v.size() != (acc ? 1 : 0) || int'(bpm_out) != m_bpm) begin
                n_bad++;
                $display("FAIL rnd%0d_result_%0d: state=%0d pulses=%0d bpm=%0d required 3/%0d/%0d",
                         r, b, s1, ov_v.size(), bpm_out, acc ? 1 : 0, m_bpm);
            end
            if (acc && ov_c.size() == 1) begin
                n_cmp++;
                if (ov_c[0] != d + 2) begin
                    n_bad++;
                    $display("FAIL rnd%0d_latency: pulse at %0d required %0d", r, ov_c[0], d + 2);
                end
            end
        end
    endtask

    task automatic test_enable_drop_and_reset();
        int c0, d, s1, s2;
        bit acc;
        feed(3, 0, -1);
        enable = 1'b0;
        tick();
        n_cmp++;
        if (state_out !== 2'd0 || ac_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_idle: state=%0d clr=%0d required 0/1", state_out, ac_clear);
        end
        n_cmp++;
        if (int'(bpm_out) != m_bpm || timeout_err !== m_terr) begin
            n_bad++;
            $display("FAIL drop_held: bpm=%0d terr=%0d required %0d/%0d", bpm_out, timeout_err, m_bpm, m_terr);
        end
        flux_in_valid = 1'b1;
        flux_in       = W'(777);
        tick();
        flux_in_valid = 1'b0;
        tick();
        n_cmp++;
        if (fq_v.size() != 3 || state_out !== 2'd0 || ac_clear !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_partial: forwards=%0d state=%0d clr=%0d required 3/0/0",
                     fq_v.size(), state_out, ac_clear);
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (state_out !== 2'd1 || ac_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL reenable: state=%0d clr=%0d required 1/1", state_out, ac_clear);
        end
        feed(N, 0, -1);
        tick();
        n_cmp++;
        if (fq_v.size() != N || state_out !== 2'd2) begin
            n_bad++;
            $display("FAIL fresh_window: forwards=%0d state=%0d required %0d/2", fq_v.size(), state_out, N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (fq_v[i] != eq_v[i] || fq_c[i] != eq_c[i]) begin
                    n_bad++;
                    $display("FAIL fresh_fwd%0d: got %0d@%0d required %0d@%0d", i, fq_v[i], fq_c[i], eq_v[i], eq_c[i]);
                end
            end
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ac_flux_valid, ac_beat_valid, ac_clear, bpm_out_valid, timeout_err} !== 5'b0 ||
            bpm_out !== '0 || ac_flux !== '0 || state_out !== 2'd0) begin
            n_bad++;
            $display("FAIL async_reset: bpm=%0d flux=%0d state=%0d required 0/0/0",
                     bpm_out, ac_flux, state_out);
        end
        c0 = clr_cnt;
        tick();
        tick();
        n_cmp++;
        if (clr_cnt != c0) begin
            n_bad++;
            $display("FAIL async_reset_clear: got %0d ac_clear pulses required 0", clr_cnt - c0);
        end
        reset  = 1'b0;
        m_bpm  = 0;
        m_hist = 1'b0;
        m_terr = 1'b0;
        tick();
        feed(N, 0, -1);
        present_result(150, d, acc, s1, s2);
        n_cmp++;
        if (ov_v.size() != 1 || int'(bpm_out) != m_bpm) begin
            n_bad++;
            $display("FAIL history_cleared: pulses=%0d bpm=%0d required 1/%0d", ov_v.size(), bpm_out, m_bpm);
        end
    endtask

    initial begin
        reset         = 1'b0;
        enable        = 1'b0;
        flux_in_valid = 1'b0;
        flux_in       = '0;
        beat_in       = 1'b0;
        ac_bpm        = '0;
        ac_bpm_valid  = 1'b0;
        test_reset();
        test_fill_window();
        test_results();
        test_timeout();
        test_timeout_race();
        test_random_results();
        test_enable_drop_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
